// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: coprocessor-0 exception/interrupt controller beside the M stage.
// Holds SR, Cause, EPC and PrID, decides when to trap and raises IntReq.
// Optional feature macro: CP0_BD_EN (delay-slot victims report the branch PC
// in EPC and set Cause.BD). Without it BD is ignored.
module cp0_exc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        We,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic [6:2]  ExcCode,
    input  logic [7:2]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    typedef enum logic {
        NORMAL  = 1'b0,
        HANDLER = 1'b1
    } exlState_t;

    localparam logic [31:0] PRID = 32'h4D49_5053;

    exlState_t   state, stateNext;
    logic [5:0]  im, imNext;
    logic        ie, ieNext;
    logic        causeBd, causeBdNext;
    logic [5:0]  ip;
    logic [4:0]  excCodeReg, excCodeNext;
    logic [31:0] epcReg, epcNext;

    logic        exl;
    logic        irq;
    logic        exc;
    logic [31:0] victimPc;
    logic        victimBd;

`ifdef CP0_BD_EN
    assign victimBd = BD;
    assign victimPc = BD ? (PC - 32'd4) : PC;
`else
    logic unusedBd;
    assign unusedBd = BD;
    assign victimBd = 1'b0;
    assign victimPc = PC;
`endif

    // Trap decision: interrupts and exceptions are both masked while in the handler.
    always_comb begin
        exl    = (state == HANDLER);
        irq    = (|(HWInt & im)) & ie & ~exl;
        exc    = (ExcCode != '0) & ~exl;
        IntReq = (irq | exc) & ~reset;
    end

    // Next-state: a trap wins over mtc0; eret clears EXL after any SR write.
    always_comb begin
        stateNext   = state;
        imNext      = im;
        ieNext      = ie;
        causeBdNext = causeBd;
        excCodeNext = excCodeReg;
        epcNext     = epcReg;
        if (IntReq) begin
            stateNext   = HANDLER;
            epcNext     = victimPc;
            causeBdNext = victimBd;
            excCodeNext = irq ? '0 : ExcCode;
        end else begin
            if (We && (A2 == 5'd12)) begin
                imNext    = DIn[15:10];
                ieNext    = DIn[0];
                stateNext = DIn[1] ? HANDLER : NORMAL;
            end
            if (We && (A2 == 5'd14)) begin
                epcNext = {DIn[31:2], 2'b00};
            end
            if (EXLClr) begin
                stateNext = NORMAL;
            end
        end
    end

    // Register update; Cause.IP tracks the interrupt lines on every edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= NORMAL;
            im         <= '0;
            ie         <= 1'b0;
            causeBd    <= 1'b0;
            ip         <= '0;
            excCodeReg <= '0;
            epcReg     <= '0;
        end else begin
            state      <= stateNext;
            im         <= imNext;
            ie         <= ieNext;
            causeBd    <= causeBdNext;
            ip         <= HWInt;
            excCodeReg <= excCodeNext;
            epcReg     <= epcNext;
        end
    end

    // mfc0 read mux and eret target.
    always_comb begin
        EPC = epcReg;
        case (A1)
            5'd12:   DOut = {16'b0, im, 8'b0, exl, ie};
            5'd13:   DOut = {causeBd, 15'b0, ip, 3'b0, excCodeReg, 2'b00};
            5'd14:   DOut = epcReg;
            5'd15:   DOut = PRID;
            default: DOut = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Testbench for cp0_exc_ctrl: directed scenarios followed by randomized
// stimulus checked against a register-level reference model.
module tb_cp0_exc_ctrl;

    localparam logic [31:0] PRID_VAL = 32'h4D49_5053;

    logic        clk;
    logic        reset;
    logic [4:0]  A1, A2;
    logic [31:0] DIn;
    logic        We;
    logic [31:0] PC;
    logic        BD;
    logic [6:2]  ExcCode;
    logic [7:2]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] DOut;

    int vecCount  = 0;
    int failCount = 0;

    // Reference model: architectural register values as whole words.
    logic [31:0] mSr, mCause, mEpc;

    cp0_exc_ctrl dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .We(We),
        .PC(PC), .BD(BD), .ExcCode(ExcCode), .HWInt(HWInt), .EXLClr(EXLClr),
        .IntReq(IntReq), .EPC(EPC), .DOut(DOut)
    );

    // 20-unit clock period
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mRead(input logic [4:0] a);
        case (a)
            5'd12:   return mSr;
            5'd13:   return mCause;
            5'd14:   return mEpc;
            5'd15:   return PRID_VAL;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic mIrq();
        return mSr[0] && !mSr[1] && ((HWInt & mSr[15:10]) != 6'd0);
    endfunction

    function automatic logic mIntReq();
        if (reset) return 1'b0;
        return mIrq() || ((ExcCode != 5'd0) && !mSr[1]);
    endfunction

    // Apply one clock edge to both model and DUT.
    task automatic tick();
        logic        bdEff;
        logic [31:0] nextSr, nextCause, nextEpc;
        if (reset) begin
            nextSr = 0; nextCause = 0; nextEpc = 0;
        end else begin
            nextSr = mSr; nextCause = mCause; nextEpc = mEpc;
`ifdef CP0_BD_EN
            bdEff = BD;
`else
            bdEff = 1'b0;
`endif
            if (mIntReq()) begin
                nextSr    = mSr | 32'h2;
                nextEpc   = bdEff ? PC - 32'd4 : PC;
                nextCause = {bdEff, 24'd0, (mIrq() ? 5'd0 : ExcCode), 2'd0};
            end else begin
                if (We && A2 == 5'd12) nextSr  = DIn & 32'h0000_FC03;
                if (We && A2 == 5'd14) nextEpc = DIn & 32'hFFFF_FFFC;
                if (EXLClr) nextSr = nextSr & ~32'h2;
            end
            nextCause[15:10] = HWInt;
        end
        @(posedge clk);
        mSr = nextSr; mCause = nextCause; mEpc = nextEpc;
        #1;
    endtask

    task automatic setIdle();
        A1 = 5'd0; A2 = 5'd0; DIn = 32'h0; We = 1'b0; PC = 32'h0;
        BD = 1'b0; ExcCode = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
    endtask

    task automatic peek(input logic [4:0] a, input string tag, input logic [31:0] exp);
        A1 = a;
        #1;
        checkVal(tag, DOut, exp);
    endtask

    task automatic checkOutputs();
        checkVal("rnd_IntReq", {31'd0, IntReq}, {31'd0, mIntReq()});
        checkVal("rnd_EPC", EPC, mEpc);
        checkVal("rnd_DOut", DOut, mRead(A1));
    endtask

    initial begin
        mSr = 0; mCause = 0; mEpc = 0;
        setIdle();
        reset = 1'b1;
        #2;
        peek(5'd15, "rst_prid", PRID_VAL);
        peek(5'd12, "rst_sr", 32'h0);
        checkVal("rst_intreq", {31'd0, IntReq}, 32'h0);
        tick();
        reset = 1'b0;

        // Interrupt taken
        setIdle(); We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
        tick();
        setIdle(); HWInt = 6'b000001; PC = 32'h3010;
        #1;
        checkVal("irq_intreq", {31'd0, IntReq}, 32'h1);
        tick();
        peek(5'd12, "irq_sr", 32'h0000_0403);
        checkVal("irq_epc", EPC, 32'h3010);
        peek(5'd13, "irq_cause", 32'h0000_0400);
        checkVal("irq_held", {31'd0, IntReq}, 32'h0);

        // Asynchronous reset while in the handler
        @(negedge clk);
        reset = 1'b1;
        peek(5'd12, "mid_rst_sr", 32'h0);
        peek(5'd13, "mid_rst_cause", 32'h0);
        peek(5'd14, "mid_rst_epc", 32'h0);
        peek(5'd15, "mid_rst_prid", PRID_VAL);
        checkVal("mid_rst_intreq", {31'd0, IntReq}, 32'h0);
        tick();
        reset = 1'b0;

        // Exception with SR=0
        setIdle(); ExcCode = 5'd4; PC = 32'h3020;
        #1;
        checkVal("exc_intreq", {31'd0, IntReq}, 32'h1);
        tick();
        peek(5'd13, "exc_cause", 32'h0000_0010);
        checkVal("exc_epc", EPC, 32'h3020);
        peek(5'd12, "exc_sr", 32'h0000_0002);
        ExcCode = 5'd5; PC = 32'h3024;
        #1;
        checkVal("exc_masked", {31'd0, IntReq}, 32'h0);
        tick();
        setIdle(); EXLClr = 1'b1;
        tick();

        // Delay-slot exception
        setIdle(); ExcCode = 5'd5; BD = 1'b1; PC = 32'h3044;
        tick();
        setIdle();
`ifdef CP0_BD_EN
        checkVal("bd_epc", EPC, 32'h3040);
        peek(5'd13, "bd_cause", 32'h8000_0014);
`else
        checkVal("bd_epc", EPC, 32'h3044);
        peek(5'd13, "bd_cause", 32'h0000_0014);
`endif
        EXLClr = 1'b1;
        tick();

        // Trap discards a simultaneous mtc0
        setIdle(); We = 1'b1; A2 = 5'd14; DIn = 32'h5000; ExcCode = 5'd12; PC = 32'h3008;
        tick();
        setIdle();
        checkVal("coll_epc", EPC, 32'h3008);
        peek(5'd13, "coll_cause", 32'h0000_0030);
        EXLClr = 1'b1;
        tick();

        // eret with a pending interrupt
        setIdle(); We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0403;
        tick();
        setIdle(); HWInt = 6'b000001; EXLClr = 1'b1;
        #1;
        checkVal("eret_intreq", {31'd0, IntReq}, 32'h0);
        tick();
        EXLClr = 1'b0;
        peek(5'd12, "eret_sr", 32'h0000_0401);
        checkVal("eret_pending", {31'd0, IntReq}, 32'h1);
        tick();

        // Randomized phase against the model
        for (int i = 0; i < 800; i++) begin
            A1      = 5'(10 + $urandom_range(0, 6));
            A2      = 5'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : 12 + $urandom_range(0, 3));
            DIn     = $urandom;
            We      = ($urandom_range(0, 2) == 0);
            PC      = $urandom & 32'hFFFF_FFFC;
            BD      = $urandom_range(0, 1) == 1;
            ExcCode = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            HWInt   = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            EXLClr  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 63) == 0) begin
                reset = 1'b1;
                mSr = 0; mCause = 0; mEpc = 0;
            end
            #1;
            checkOutputs();
            tick();
            reset = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Coprocessor-0 exception/interrupt controller for the five-stage MIPS pipeline. It sits beside the M stage. It takes the M-stage exception code and PC, the six hardware interrupt lines and the mtc0/eret controls. It holds SR, Cause, EPC and PrID, decides when to trap, and drives the pipeline-wide IntReq flush/redirect request. The mfc0 read data and the eret return target also come from this block.

## Interface
- No parameters.
- `clk  in  1`: system clock; all state updates on the rising edge.
- `reset  in  1`: asynchronous, active-high; clears all state immediately.
- `A1  in  5`: mfc0 read register number.
- `A2  in  5`: mtc0 write register number.
- `DIn  in  32`: mtc0 write data.
- `We  in  1`: mtc0 write enable (M stage).
- `PC  in  32`: PC of the instruction currently in M.
- `BD  in  1`: the M instruction is in a branch delay slot.
- `ExcCode  in  5 [6:2]`: M-stage exception code; 0 means no exception.
- `HWInt  in  6 [7:2]`: hardware interrupt lines, level-sensitive.
- `EXLClr  in  1`: eret in M.
- `IntReq  out  1`: take exception/interrupt this cycle (flush pipeline, fetch handler 0x4180).
- `EPC  out  32`: current EPC register (eret target).
- `DOut  out  32`: mfc0 read data.

## Operation
- Register 12, SR: IM[15:10], EXL[1], IE[0]; all other bits read 0.
- Register 13, Cause: BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0. Read-only to mtc0.
- Register 14, EPC: 32 bits; mtc0 writes force bits [1:0] to 0.
- Register 15, PrID: constant 32'h4D49_5053.
- Any other A1 reads 0. mtc0 to 13, to 15 or to an unlisted number is ignored.
- `irq = |(HWInt & SR.IM) & SR.IE & !SR.EXL`.
- `exc = (ExcCode != 0) & !SR.EXL`.
- `IntReq = irq | exc`.
- Priority: interrupt over exception. When irq is taken, Cause.ExcCode is set to 0. When only exc is taken, Cause.ExcCode is set to ExcCode.
- On an edge with IntReq=1: SR.EXL ← 1; EPC ← victim PC (see Configuration); Cause.BD ← BD as per Configuration; the mtc0 write in that cycle is discarded.
- On an edge with IntReq=0:
  - We applies the write.
  - EXLClr clears SR.EXL. If EXLClr and a write to SR happen together, the write is applied first and EXL is then forced to 0.
- Cause.IP ← HWInt on every edge, unconditionally, including trap cycles.
- State machine on SR.EXL:
  - NORMAL (EXL=0) → HANDLER on IntReq.
  - HANDLER (EXL=1) → NORMAL on EXLClr, or on an mtc0 that clears EXL.
  - In HANDLER, IntReq is held at 0 regardless of inputs.

## Timing
- IntReq, DOut and EPC are combinational from current state and inputs; zero-latency read.
- Writes and trap updates become visible on the cycle after the edge. There is no write-to-read bypass; mtc0→mfc0 hazards are handled by pipeline stalls.
- Reset values:
  - SR = 0, Cause = 0, EPC = 0.
  - IntReq = 0 while reset is asserted.
  - DOut = 0 except for A1=15, which reads PrID.
- Reset asserted mid-trap: all registers clear asynchronously, and the pending trap is lost.
- EXLClr with EXL=0 has no effect.
- A HWInt pulse shorter than one cycle may be missed. Lines must be held until software acknowledges them.

## Configuration
- `CP0_BD_EN` defined: when the victim has BD=1, EPC ← PC−4 (the branch) and Cause.BD ← 1. When BD=0, EPC ← PC and Cause.BD ← 0.
- `CP0_BD_EN` undefined: the BD input is ignored; EPC ← PC always; Cause.BD always reads 0.

## Test plan
- Reset behaviour: drive reset=1 mid-run with EXL=1 and EPC=0x3010. Required: SR, Cause and EPC read 0 immediately; IntReq=0; DOut(A1=15)=32'h4D49_5053.
- Interrupt taken:
  - Stimulus: mtc0 SR=32'h0000_0401; then HWInt=6'b000001, PC=0x3010.
  - Required: IntReq=1 in the same cycle.
  - After the edge: SR reads 32'h0000_0403, EPC=0x3010, Cause=32'h0000_0400, and IntReq=0 while HWInt is still high.
- Exception taken with SR=0:
  - Stimulus: ExcCode=4, PC=0x3020.
  - Required: IntReq=1. After the edge: Cause[6:2]=4, EPC=0x3020, EXL=1.
  - A following ExcCode=5 leaves IntReq=0.
- Delay-slot exception: ExcCode=5, BD=1, PC=0x3044.
  - With CP0_BD_EN: EPC=0x3040, Cause=32'h8000_0014.
  - Without CP0_BD_EN: EPC=0x3044, Cause=32'h0000_0014.
- Trap/write collision: We=1, A2=14, DIn=0x5000 in the same cycle as ExcCode=12, PC=0x3008. Required: EPC=0x3008 and Cause[6:2]=12.
- eret with pending interrupt: EXLClr=1 while EXL=1, SR.IM[10]=1, IE=1, HWInt[2]=1.
  - Required: IntReq=0 in the eret cycle.
  - Next cycle: EXL=0 and IntReq=1.
